alloc_pool: RTL and testbench
=============================

Name: alloc_pool

Overview:
Parametrised cell allocator, the successor to the fixed-size alloc block. It manages a pool of 2**ADDR_WIDTH cells, each DATA_WIDTH bits wide, stored in dual-port RAM. The pool is filled from a bump pointer (top) plus a linked free list threaded through the freed cells. It sits between the core/test fixture and cell memory, and adds three things: combined alloc+free reuse in one cycle, an independent read port, and error/occupancy reporting.

Parameters:
DATA_WIDTH, 16, bits per cell; must be >= ADDR_WIDTH, because a free cell holds its next-link in bits [ADDR_WIDTH-1:0].
ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH.
RESERVED, 1, number of low cells never allocated; cell 0 is NIL; must satisfy 1 <= RESERVED < DEPTH.

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous active-high reset
i_alloc  in  1  allocate request, sampled only while o_ready=1
i_adata  in  DATA_WIDTH  initial contents of the new cell
i_free  in  1  free request, sampled only while o_ready=1
i_faddr  in  ADDR_WIDTH  cell to release
i_rd  in  1  read request, independent of o_ready
i_raddr  in  ADDR_WIDTH  read address
o_rdata  out  DATA_WIDTH  read data
o_rvalid  out  1  o_rdata valid (1-cycle pulse)
o_ready  out  1  engine accepts alloc/free this cycle
o_done  out  1  1-cycle pulse: o_addr holds the newly allocated cell
o_addr  out  ADDR_WIDTH  allocated address, held until the next o_done
o_err  out  1  1-cycle pulse: request rejected
o_count  out  ADDR_WIDTH  number of cells currently allocated

Behaviour:
- Reset (i_rst=1 at a clock edge, including mid-operation):
  - state=IDLE, top=RESERVED, free=NIL, count=0.
  - o_ready=1; o_done, o_err, o_rvalid=0; o_addr=0; o_rdata=0.
  - RAM contents are not cleared.
- States: IDLE, POP.
  - o_ready=1 only in IDLE.
  - Requests presented while o_ready=0 are ignored; no queueing.
- Alloc only, free==NIL, top<DEPTH:
  - mem[top]<=i_adata; o_addr<=top; top<=top+1; count+1.
  - o_done next cycle (latency 1); stay in IDLE.
- Alloc only, free!=NIL:
  - Cycle 0: issue a read of mem[free]; go to POP; o_ready=0.
  - Cycle 1 (POP): next<=rdata[ADDR_WIDTH-1:0]; mem[free]<=i_adata as captured in cycle 0; o_addr<=free; free<=next; count+1; o_done; return to IDLE.
  - Latency 2. The free list takes priority over top.
- Alloc only, free==NIL and top==DEPTH (exhausted): o_err pulse; no state change; no o_done.
- Free only, RESERVED<=i_faddr<top: mem[i_faddr]<=free (zero-extended link); free<=i_faddr; count-1; latency 1.
- Free of an invalid address (i_faddr<RESERVED or i_faddr>=top): o_err pulse; ignored.
- Double-free is not detected (caller responsibility).
- Alloc+free in the same cycle with a valid i_faddr:
  - mem[i_faddr]<=i_adata; o_addr<=i_faddr; o_done next cycle.
  - free, top and count are unchanged; latency 1, even if the free list is non-empty.
- Alloc+free with an invalid i_faddr: o_err pulse; the alloc is also dropped.
- Read port:
  - i_rd -> o_rdata=mem[i_raddr], o_rvalid the next cycle.
  - Same-cycle write to the same address returns the old data (read-before-write).
  - Available during POP and while o_ready=0.
- Arithmetic:
  - top is ADDR_WIDTH+1 bits so it can reach DEPTH.
  - count never exceeds DEPTH-RESERVED and never underflows, because invalid frees are rejected.

Decomposition:
- Package alloc_pkg: NIL constant, state encoding (IDLE, POP), and the link-field extraction width rule.
- Sub-module alloc_ram: simple dual-port synchronous RAM.
  - Port A: read/write, used by the engine.
  - Port B: read-only, used by the read port.
  - Both ports have 1-cycle read latency.

Test Plan:
1. Reset, then 3 allocs (data 0xA1, 0xA2, 0xA3, ADDR_WIDTH=8) -> o_addr 1, 2, 3, each o_done 1 cycle after request; o_count=3; reads of 1..3 return A1..A3.
2. Free 2 then free 1; alloc 0xB0 -> o_ready low 1 cycle, o_done at +2, o_addr=1; next alloc -> o_addr=2; next alloc -> o_addr=4 (bump pointer); o_count=4.
3. With the free list non-empty, simultaneous alloc 0xC5 + free 3 -> o_addr=3 at +1, o_count unchanged, free list head unchanged (the next alloc returns the old head).
4. Exhaust the pool (ADDR_WIDTH=3: 7 allocs, addresses 1..7); 8th alloc -> o_err pulse, no o_done, o_count=7; then free 0 -> o_err; free 7 -> accepted, o_count=6.
5. Assert i_rst during POP -> next cycle o_ready=1, o_count=0; next alloc returns o_addr=RESERVED.
6. Read 5 in the same cycle as an alloc writing 5 -> o_rdata is the old value; a re-read returns the new value.

Source files
------------

// File: rtl/alloc_pkg.sv
// Shared definitions for the cell allocator: NIL address, engine states and
// the rule for how many low bits of a free cell carry its next-link.
package alloc_pkg;

    localparam int NIL = 0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        POP  = 1'b1
    } state_t;

    // The link lives in the low bits of a free cell; it can never be wider than the cell.
    function automatic int link_width(input int data_w, input int addr_w);
        return (addr_w < data_w) ? addr_w : data_w;
    endfunction

endpackage

// File: rtl/alloc_ram.sv
// Simple dual-port synchronous RAM: port A read/write for the engine, port B
// read-only for the external read port. Both reads are registered, read-before-write.
module alloc_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_en,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (a_en) begin
            if (a_we) begin
                mem[a_addr] <= a_wdata;
            end
            a_rdata <= mem[a_addr];
        end
    end

    // Output register reset keeps the external read data at zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_rdata <= '0;
        end else if (b_en) begin
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/alloc_pool.sv
// Cell allocator: bump pointer plus a free list threaded through freed cells,
// with same-cycle alloc+free reuse, an independent read port and occupancy count.
module alloc_pool
    import alloc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int RESERVED   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_alloc,
    input  logic [DATA_WIDTH-1:0] i_adata,
    input  logic                  i_free,
    input  logic [ADDR_WIDTH-1:0] i_faddr,
    input  logic                  i_rd,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_rvalid,
    output logic                  o_ready,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_err,
    output logic [ADDR_WIDTH-1:0] o_count
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int TOP_W  = ADDR_WIDTH + 1;
    localparam int LINK_W = link_width(DATA_WIDTH, ADDR_WIDTH);

    localparam logic [ADDR_WIDTH-1:0] NIL_ADDR  = ADDR_WIDTH'(NIL);
    localparam logic [ADDR_WIDTH-1:0] RES_ADDR  = ADDR_WIDTH'(RESERVED);
    localparam logic [TOP_W-1:0]      TOP_INIT  = TOP_W'(RESERVED);
    localparam logic [TOP_W-1:0]      TOP_LIMIT = TOP_W'(DEPTH);

    state_t                state_reg, state_next;
    logic [TOP_W-1:0]      top_reg, top_next;
    logic [ADDR_WIDTH-1:0] free_reg, free_next;
    logic [ADDR_WIDTH-1:0] count_reg, count_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_WIDTH-1:0] pend_reg, pend_next;
    logic                  done_reg, done_next;
    logic                  err_reg, err_next;
    logic                  rvalid_reg;

    logic                  a_en, a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata, a_rdata;
    logic [ADDR_WIDTH-1:0] link;
    logic                  link_unused;
    logic                  faddr_ok, has_free, has_room;

    alloc_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (i_clk),
        .rst    (i_rst),
        .a_en   (a_en),
        .a_we   (a_we),
        .a_addr (a_addr),
        .a_wdata(a_wdata),
        .a_rdata(a_rdata),
        .b_en   (i_rd),
        .b_addr (i_raddr),
        .b_rdata(o_rdata)
    );

    assign link        = ADDR_WIDTH'(a_rdata[LINK_W-1:0]);
    assign link_unused = ^a_rdata;
    assign faddr_ok    = (i_faddr >= RES_ADDR) && ({1'b0, i_faddr} < top_reg);
    assign has_free    = (free_reg != NIL_ADDR);
    assign has_room    = (top_reg < TOP_LIMIT);

    always_comb begin
        state_next = state_reg;
        top_next   = top_reg;
        free_next  = free_reg;
        count_next = count_reg;
        addr_next  = addr_reg;
        pend_next  = pend_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        a_en       = 1'b0;
        a_we       = 1'b0;
        a_addr     = free_reg;
        a_wdata    = pend_reg;

        case (state_reg)
            IDLE: begin
                if (i_alloc && i_free) begin
                    // Hand the freed cell straight back; pool bookkeeping is untouched.
                    if (faddr_ok) begin
                        a_en      = 1'b1;
                        a_we      = 1'b1;
                        a_addr    = i_faddr;
                        a_wdata   = i_adata;
                        addr_next = i_faddr;
                        done_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (i_alloc) begin
                    if (has_free) begin
                        a_en       = 1'b1;
                        a_addr     = free_reg;
                        pend_next  = i_adata;
                        state_next = POP;
                    end else if (has_room) begin
                        a_en       = 1'b1;
                        a_we       = 1'b1;
                        a_addr     = top_reg[ADDR_WIDTH-1:0];
                        a_wdata    = i_adata;
                        addr_next  = top_reg[ADDR_WIDTH-1:0];
                        top_next   = top_reg + 1'b1;
                        count_next = count_reg + 1'b1;
                        done_next  = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (i_free) begin
                    if (faddr_ok) begin
                        a_en       = 1'b1;
                        a_we       = 1'b1;
                        a_addr     = i_faddr;
                        a_wdata    = DATA_WIDTH'(free_reg);
                        free_next  = i_faddr;
                        count_next = count_reg - 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            POP: begin
                // a_rdata now holds the head cell; its low bits are the next link.
                a_en       = 1'b1;
                a_we       = 1'b1;
                a_addr     = free_reg;
                a_wdata    = pend_reg;
                addr_next  = free_reg;
                free_next  = link;
                count_next = count_reg + 1'b1;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (i_rst) begin
            a_en = 1'b0;
            a_we = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg  <= IDLE;
            top_reg    <= TOP_INIT;
            free_reg   <= NIL_ADDR;
            count_reg  <= '0;
            addr_reg   <= '0;
            pend_reg   <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            rvalid_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            top_reg    <= top_next;
            free_reg   <= free_next;
            count_reg  <= count_next;
            addr_reg   <= addr_next;
            pend_reg   <= pend_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
            rvalid_reg <= i_rd;
        end
    end

    assign o_ready  = (state_reg == IDLE);
    assign o_done   = done_reg;
    assign o_err    = err_reg;
    assign o_addr   = addr_reg;
    assign o_count  = count_reg;
    assign o_rvalid = rvalid_reg;

endmodule

// File: tb/tb_alloc_pool.sv
// Bench for alloc_pool: a default 8-bit-address instance driven from a vector
// table, plus a 3-bit-address instance for pool exhaustion.
module tb_alloc_pool;

    localparam int K_NONE = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef struct packed {
        logic        alloc;
        logic [15:0] adata;
        logic        free;
        logic [7:0]  faddr;
        logic        rd;
        logic [7:0]  raddr;
        int          kind;
        int          lat;
        logic [7:0]  exp_addr;
        logic [7:0]  exp_count;
        logic [15:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, alloc, free, rd;
    logic [15:0] adata;
    logic [7:0]  faddr, raddr;
    logic [15:0] rdata;
    logic        rvalid, ready, done, err;
    logic [7:0]  addr, count;

    logic        s_rst, s_alloc, s_free, s_rd;
    logic [7:0]  s_adata;
    logic [2:0]  s_faddr, s_raddr;
    logic [7:0]  s_rdata;
    logic        s_rvalid, s_ready, s_done, s_err;
    logic [2:0]  s_addr, s_count;

    int n_pass  = 0;
    int n_total = 0;

    alloc_pool u_dut (
        .i_clk(clk), .i_rst(rst), .i_alloc(alloc), .i_adata(adata),
        .i_free(free), .i_faddr(faddr), .i_rd(rd), .i_raddr(raddr),
        .o_rdata(rdata), .o_rvalid(rvalid), .o_ready(ready), .o_done(done),
        .o_addr(addr), .o_err(err), .o_count(count)
    );

    alloc_pool #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .RESERVED(1)) u_small (
        .i_clk(clk), .i_rst(s_rst), .i_alloc(s_alloc), .i_adata(s_adata),
        .i_free(s_free), .i_faddr(s_faddr), .i_rd(s_rd), .i_raddr(s_raddr),
        .o_rdata(s_rdata), .o_rvalid(s_rvalid), .o_ready(s_ready), .o_done(s_done),
        .o_addr(s_addr), .o_err(s_err), .o_count(s_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic a, input logic [15:0] d, input logic f,
                                input logic [7:0] fa, input logic r, input logic [7:0] ra,
                                input int kind, input int lat, input logic [7:0] ea,
                                input logic [7:0] ec, input logic [15:0] er);
        vec_t v;
        v.alloc = a; v.adata = d; v.free = f; v.faddr = fa; v.rd = r; v.raddr = ra;
        v.kind = kind; v.lat = lat; v.exp_addr = ea; v.exp_count = ec; v.exp_rdata = er;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        bit got_done, got_err;
        int lat;
        logic [7:0]  cap_addr;
        logic        rdy1, rv1;
        logic [15:0] rd1;
        got_done = 0; got_err = 0; lat = 0; cap_addr = '0;
        rdy1 = 1'b0; rv1 = 1'b0; rd1 = '0;
        @(negedge clk);
        alloc = v.alloc; adata = v.adata; free = v.free; faddr = v.faddr;
        rd = v.rd; raddr = v.raddr;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            if (n == 1) begin
                alloc = 1'b0; free = 1'b0; rd = 1'b0;
                rdy1 = ready; rv1 = rvalid; rd1 = rdata;
            end
            if (done && !got_done) begin got_done = 1; lat = n; cap_addr = addr; end
            if (err && !got_err) begin got_err = 1; if (!got_done) lat = n; end
        end
        $display("vec %0d: alloc=%0b free=%0b faddr=%0d rd=%0b done=%0b err=%0b lat=%0d addr=%0d count=%0d",
                 idx, v.alloc, v.free, v.faddr, v.rd, got_done, got_err, lat, cap_addr, count);
        check($sformatf("v%0d ready", idx), 32'(rdy1),
              (v.kind == K_DONE && v.lat == 2) ? 32'd0 : 32'd1);
        check($sformatf("v%0d rvalid", idx), 32'(rv1), 32'(v.rd));
        if (v.rd) check($sformatf("v%0d rdata", idx), 32'(rd1), 32'(v.exp_rdata));
        case (v.kind)
            K_DONE: begin
                check($sformatf("v%0d done", idx), 32'(got_done), 32'd1);
                check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
                check($sformatf("v%0d addr", idx), 32'(cap_addr), 32'(v.exp_addr));
            end
            K_ERR: begin
                check($sformatf("v%0d err", idx), 32'(got_err), 32'd1);
                check($sformatf("v%0d err_lat", idx), 32'(lat), 32'd1);
                check($sformatf("v%0d no_done", idx), 32'(got_done), 32'd0);
            end
            default: begin
                check($sformatf("v%0d no_done", idx), 32'(got_done), 32'd0);
                check($sformatf("v%0d no_err", idx), 32'(got_err), 32'd0);
            end
        endcase
        check($sformatf("v%0d count", idx), 32'(count), 32'(v.exp_count));
    endtask

    task automatic s_op(input logic a, input logic [7:0] d, input logic f, input logic [2:0] fa,
                        output bit gd, output bit ge, output int lat, output logic [2:0] ad);
        gd = 0; ge = 0; lat = 0; ad = '0;
        @(negedge clk);
        s_alloc = a; s_adata = d; s_free = f; s_faddr = fa;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            if (n == 1) begin s_alloc = 1'b0; s_free = 1'b0; end
            if (s_done && !gd) begin gd = 1; lat = n; ad = s_addr; end
            if (s_err && !ge) begin ge = 1; if (!gd) lat = n; end
        end
        $display("small: alloc=%0b free=%0b faddr=%0d done=%0b err=%0b lat=%0d addr=%0d count=%0d",
                 a, f, fa, gd, ge, lat, ad, s_count);
    endtask

    vec_t vecs[$];

    initial begin
        bit gd, ge;
        int lat;
        logic [2:0] sad;

        vecs.push_back(mk(1, 16'h00A1, 0, 0, 0, 0, K_DONE, 1, 1, 1, 0));
        vecs.push_back(mk(1, 16'h00A2, 0, 0, 0, 0, K_DONE, 1, 2, 2, 0));
        vecs.push_back(mk(1, 16'h00A3, 0, 0, 0, 0, K_DONE, 1, 3, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, K_NONE, 0, 0, 3, 16'h00A1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 2, K_NONE, 0, 0, 3, 16'h00A2));
        vecs.push_back(mk(0, 0, 0, 0, 1, 3, K_NONE, 0, 0, 3, 16'h00A3));
        vecs.push_back(mk(0, 0, 1, 2, 0, 0, K_NONE, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, K_NONE, 0, 0, 1, 0));
        vecs.push_back(mk(1, 16'h00B0, 0, 0, 0, 0, K_DONE, 2, 1, 2, 0));
        vecs.push_back(mk(1, 16'h00B1, 0, 0, 0, 0, K_DONE, 2, 2, 3, 0));
        vecs.push_back(mk(1, 16'h00B2, 0, 0, 0, 0, K_DONE, 1, 4, 4, 0));
        vecs.push_back(mk(0, 0, 1, 2, 0, 0, K_NONE, 0, 0, 3, 0));
        vecs.push_back(mk(1, 16'h00C5, 1, 3, 0, 0, K_DONE, 1, 3, 3, 0));
        vecs.push_back(mk(1, 16'h00D0, 0, 0, 0, 0, K_DONE, 2, 2, 4, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 3, K_NONE, 0, 0, 4, 16'h00C5));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, K_NONE, 0, 0, 4, 16'h00B0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, K_ERR, 1, 0, 4, 0));
        vecs.push_back(mk(0, 0, 1, 9, 0, 0, K_ERR, 1, 0, 4, 0));
        vecs.push_back(mk(1, 16'h0099, 1, 9, 0, 0, K_ERR, 1, 0, 4, 0));
        vecs.push_back(mk(1, 16'h00E5, 0, 0, 0, 0, K_DONE, 1, 5, 5, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 5, K_NONE, 0, 0, 5, 16'h00E5));
        vecs.push_back(mk(1, 16'h00F6, 1, 5, 1, 5, K_DONE, 1, 5, 5, 16'h00E5));
        vecs.push_back(mk(0, 0, 0, 0, 1, 5, K_NONE, 0, 0, 5, 16'h00F6));
        vecs.push_back(mk(0, 0, 1, 4, 0, 0, K_NONE, 0, 0, 4, 0));

        rst = 1'b1; alloc = 0; adata = '0; free = 0; faddr = '0; rd = 0; raddr = '0;
        s_rst = 1'b1; s_alloc = 0; s_adata = '0; s_free = 0; s_faddr = '0; s_rd = 0; s_raddr = '0;
        repeat (3) @(negedge clk);
        $display("reset: ready=%0b done=%0b err=%0b addr=%0d count=%0d rvalid=%0b rdata=%0h",
                 ready, done, err, addr, count, rvalid, rdata);
        check("rst ready", 32'(ready), 32'd1);
        check("rst done", 32'(done), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst addr", 32'(addr), 32'd0);
        check("rst count", 32'(count), 32'd0);
        check("rst rvalid", 32'(rvalid), 32'd0);
        check("rst rdata", 32'(rdata), 32'd0);
        check("rst s_ready", 32'(s_ready), 32'd1);
        check("rst s_count", 32'(s_count), 32'd0);
        rst = 1'b0; s_rst = 1'b0;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Reset while the engine is in POP (free list head is cell 4).
        @(negedge clk);
        alloc = 1'b1; adata = 16'h0055;
        @(negedge clk);
        alloc = 1'b0;
        $display("pop: ready=%0b", ready);
        check("pop ready", 32'(ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("pop reset: ready=%0b count=%0d done=%0b", ready, count, done);
        check("poprst ready", 32'(ready), 32'd1);
        check("poprst count", 32'(count), 32'd0);
        check("poprst done", 32'(done), 32'd0);
        run_vec(100, mk(1, 16'h0077, 0, 0, 0, 0, K_DONE, 1, 1, 1, 0));

        // Exhaust the 8-cell pool: cells 1..7 are allocatable.
        for (int i = 1; i <= 7; i++) begin
            s_op(1, 8'(i), 0, 0, gd, ge, lat, sad);
            check($sformatf("s%0d done", i), 32'(gd), 32'd1);
            check($sformatf("s%0d lat", i), 32'(lat), 32'd1);
            check($sformatf("s%0d addr", i), 32'(sad), 32'(i));
        end
        check("s count7", 32'(s_count), 32'd7);
        s_op(1, 8'h88, 0, 0, gd, ge, lat, sad);
        check("s full err", 32'(ge), 32'd1);
        check("s full no_done", 32'(gd), 32'd0);
        check("s full count", 32'(s_count), 32'd7);
        s_op(0, 0, 1, 3'd0, gd, ge, lat, sad);
        check("s free0 err", 32'(ge), 32'd1);
        check("s free0 count", 32'(s_count), 32'd7);
        s_op(0, 0, 1, 3'd7, gd, ge, lat, sad);
        check("s free7 no_err", 32'(ge), 32'd0);
        check("s free7 count", 32'(s_count), 32'd6);
        s_op(1, 8'h5A, 0, 0, gd, ge, lat, sad);
        check("s reuse done", 32'(gd), 32'd1);
        check("s reuse lat", 32'(lat), 32'd2);
        check("s reuse addr", 32'(sad), 32'd7);
        check("s reuse count", 32'(s_count), 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
